// File: rtl/regfile_source.sv
// regfile_source: per-register in-flight producer tracker (queue tag + pending bit).
// Optional `RFSRC_PENDCNT_EN adds a registered popcount of pending registers on pend_count.
`ifndef QENTRIES
`define QENTRIES 8
`endif
`ifndef QSLOTS
`define QSLOTS 3
`endif

module regfile_source #(
    parameter int AREGS    = 128,
    parameter int RBIT     = 6,
    parameter int QENTRIES = `QENTRIES,
    parameter int QSLOTS   = `QSLOTS,
    parameter int QBITW    = $clog2(QENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [QSLOTS-1:0]           slotvd,
    input  logic [QSLOTS-1:0]           slot_rfw,
    input  logic [QSLOTS-1:0]           queuedOn,
    input  logic [QSLOTS*(RBIT+1)-1:0]  Rd,
    input  logic [QSLOTS*QBITW-1:0]     tails,
    input  logic                        branchmiss,
    input  logic [AREGS-1:0]            livetarget,
    input  logic                        commit0_v,
    input  logic                        commit1_v,
    input  logic [QBITW-1:0]            commit0_id,
    input  logic [QBITW-1:0]            commit1_id,
    input  logic [RBIT:0]               commit0_tgt,
    input  logic [RBIT:0]               commit1_tgt,
    output logic [AREGS*QBITW-1:0]      rf_source,
    output logic [AREGS-1:0]            rf_srcv,
    output logic [RBIT+1:0]             pend_count
);
    logic [QBITW-1:0] r_src [AREGS];
    logic [QBITW-1:0] w_src_nxt [AREGS];
    logic [AREGS-1:0] r_srcv, w_srcv_nxt;
    logic             w_ok;
    logic [RBIT:0]    w_rd;

    always_comb begin
        w_src_nxt  = r_src;
        w_srcv_nxt = branchmiss ? (r_srcv & livetarget) : r_srcv;
        w_ok       = 1'b1;
        w_rd       = '0;
        if (commit0_v && r_srcv[commit0_tgt] && r_src[commit0_tgt] == commit0_id)
            w_srcv_nxt[commit0_tgt] = 1'b0;
        if (commit1_v && r_srcv[commit1_tgt] && r_src[commit1_tgt] == commit1_id)
            w_srcv_nxt[commit1_tgt] = 1'b0;
        // Ascending slot order lets the highest claiming slot win; an unqueued valid slot stops the chain.
        for (int k = 0; k < QSLOTS; k++) begin
            w_rd = Rd[k*(RBIT+1) +: RBIT+1];
            if (!branchmiss && w_ok && slotvd[k] && queuedOn[k] && slot_rfw[k]) begin
                w_src_nxt[w_rd]  = tails[k*QBITW +: QBITW];
                w_srcv_nxt[w_rd] = 1'b1;
            end
            if (slotvd[k] && !queuedOn[k])
                w_ok = 1'b0;
        end
        w_srcv_nxt[0]       = 1'b0;
        w_srcv_nxt[AREGS/2] = 1'b0;
        w_src_nxt[0]        = '0;
        w_src_nxt[AREGS/2]  = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_srcv <= '0;
            for (int n = 0; n < AREGS; n++)
                r_src[n] <= '0;
        end else begin
            r_srcv <= w_srcv_nxt;
            r_src  <= w_src_nxt;
        end
    end

    for (genvar i = 0; i < AREGS; i++) begin : g_src
        assign rf_source[i*QBITW +: QBITW] = r_src[i];
    end
    assign rf_srcv = r_srcv;

`ifdef RFSRC_PENDCNT_EN
    logic [RBIT+1:0] r_cnt, w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int n = 0; n < AREGS; n++)
            w_cnt = w_cnt + {{(RBIT+1){1'b0}}, w_srcv_nxt[n]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt;
    end
    assign pend_count = r_cnt;
`else
    assign pend_count = '0;
`endif
endmodule

// File: tb/tb_regfile_source.sv
// tb_regfile_source: directed vectors against hand-computed tags, pending bits and counts.
module tb_regfile_source;
    localparam int AREGS = 128;
    localparam int RBIT  = 6;
    localparam int QS    = 3;
    localparam int QB    = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [QS-1:0]          slotvd, slot_rfw, queuedOn;
    logic [QS*(RBIT+1)-1:0] Rd;
    logic [QS*QB-1:0]       tails;
    logic                   branchmiss;
    logic [AREGS-1:0]       livetarget;
    logic                   commit0_v, commit1_v;
    logic [QB-1:0]          commit0_id, commit1_id;
    logic [RBIT:0]          commit0_tgt, commit1_tgt;
    logic [AREGS*QB-1:0]    rf_source;
    logic [AREGS-1:0]       rf_srcv;
    logic [RBIT+1:0]        pend_count;
    int n_chk = 0;
    int n_pass = 0;

    regfile_source #(.AREGS(AREGS), .RBIT(RBIT), .QENTRIES(8), .QSLOTS(QS)) dut (
        .clk(clk), .rst(rst), .slotvd(slotvd), .slot_rfw(slot_rfw), .queuedOn(queuedOn),
        .Rd(Rd), .tails(tails), .branchmiss(branchmiss), .livetarget(livetarget),
        .commit0_v(commit0_v), .commit1_v(commit1_v), .commit0_id(commit0_id),
        .commit1_id(commit1_id), .commit0_tgt(commit0_tgt), .commit1_tgt(commit1_tgt),
        .rf_source(rf_source), .rf_srcv(rf_srcv), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic chk_pend(input string tag, input int exp);
`ifdef RFSRC_PENDCNT_EN
        chk(tag, 32'(pend_count), exp);
`else
        chk(tag, 32'(pend_count), 0);
`endif
    endtask

    function automatic logic [31:0] src(input int r);
        return 32'(rf_source[r*QB +: QB]);
    endfunction

    task automatic idle();
        slotvd = '0; slot_rfw = '0; queuedOn = '0; Rd = '0; tails = '0;
        branchmiss = 1'b0; livetarget = '0;
        commit0_v = 1'b0; commit1_v = 1'b0; commit0_id = '0; commit1_id = '0;
        commit0_tgt = '0; commit1_tgt = '0;
    endtask

    task automatic slot(input int k, input int rd, input int tail, input bit v, input bit q, input bit w);
        slotvd[k] = v; queuedOn[k] = q; slot_rfw[k] = w;
        Rd[k*(RBIT+1) +: RBIT+1] = 7'(rd);
        tails[k*QB +: QB] = 3'(tail);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        #12;
        chk("rst_srcv", 32'(rf_srcv != '0), 0);
        chk("rst_src", 32'(rf_source != '0), 0);
        chk_pend("rst_pend", 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        slot(0, 5, 3, 1, 1, 1); tick();
        chk("c5_src", src(5), 3);
        chk("c5_v", 32'(rf_srcv[5]), 1);
        chk_pend("c5_pend", 1);

        slot(0, 9, 1, 1, 1, 1); slot(1, 9, 2, 1, 1, 1); slot(2, 9, 4, 1, 1, 1); tick();
        chk("hi_wins", src(9), 4);
        chk_pend("hi_pend", 2);

        slot(0, 10, 1, 1, 1, 1); slot(1, 11, 2, 1, 0, 1); slot(2, 12, 3, 1, 1, 1); tick();
        chk("chain10", 32'(rf_srcv[10]), 1);
        chk("chain11", 32'(rf_srcv[11]), 0);
        chk("chain12", 32'(rf_srcv[12]), 0);
        chk_pend("chain_pend", 3);

        slot(0, 7, 2, 1, 1, 1); tick();
        commit0_v = 1; commit0_id = 2; commit0_tgt = 7; tick();
        chk("cm_match", 32'(rf_srcv[7]), 0);
        chk_pend("cm_pend", 3);
        slot(0, 7, 6, 1, 1, 1); tick();
        commit0_v = 1; commit0_id = 2; commit0_tgt = 7;
        commit1_v = 1; commit1_id = 3; commit1_tgt = 5; tick();
        chk("cm_stale", 32'(rf_srcv[7]), 1);
        chk("cm_stale_src", src(7), 6);
        chk("cm1_match", 32'(rf_srcv[5]), 0);
        chk("cm_keep_src", src(5), 3);
        chk_pend("cm1_pend", 3);

        slot(0, 8, 1, 1, 1, 1); tick();
        commit0_v = 1; commit0_id = 1; commit0_tgt = 8; slot(0, 8, 5, 1, 1, 1); tick();
        chk("enq_over_cm_v", 32'(rf_srcv[8]), 1);
        chk("enq_over_cm_src", src(8), 5);
        chk_pend("enq_cm_pend", 4);

        slot(0, 20, 1, 1, 1, 1); slot(1, 21, 2, 1, 1, 1); tick();
        chk_pend("pre_bm_pend", 6);
        branchmiss = 1; livetarget = '1; livetarget[20] = 1'b0;
        slot(0, 30, 7, 1, 1, 1); tick();
        chk("bm20", 32'(rf_srcv[20]), 0);
        chk("bm21", 32'(rf_srcv[21]), 1);
        chk("bm30_v", 32'(rf_srcv[30]), 0);
        chk("bm30_src", src(30), 0);
        chk("bm9_kept", 32'(rf_srcv[9]), 1);
        chk_pend("bm_pend", 5);

        slot(0, 0, 3, 1, 1, 1); slot(1, 64, 4, 1, 1, 1); tick();
        chk("r0_v", 32'(rf_srcv[0]), 0);
        chk("r64_v", 32'(rf_srcv[64]), 0);
        chk("r0_src", src(0), 0);
        chk("r64_src", src(64), 0);

        slot(0, 40, 5, 1, 1, 1); #1;
        chk("no_comb_path", 32'(rf_srcv[40]), 0);
        tick();
        chk("r40_v", 32'(rf_srcv[40]), 1);
        #2 rst = 1'b1; #1;
        chk("async_rst_v", 32'(rf_srcv != '0), 0);
        chk("async_rst_src", 32'(rf_source != '0), 0);
        chk_pend("async_rst_pend", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
